// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output serializer.
package fft_pkg;

    localparam int FFT_DW = 16;  // default sample width
    localparam int N_PTS  = 8;   // bins per frame
    localparam int LOG2N  = 3;   // log2(N_PTS)

    typedef logic [LOG2N-1:0] bin_idx_t;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_frame_buf.sv
// One frame of complex bins: written all at once, read one bin at a time.
// Each entry is packed as {re, im}. Contents need no reset because the
// occupancy count in the parent decides what is valid.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [N_PTS-1:0][2*DW-1:0]    wdata_i,
    input  bin_idx_t                      rd_idx_i,
    output logic [2*DW-1:0]               rdata_o
);

    logic [N_PTS-1:0][2*DW-1:0] mem_q;

    // Parallel capture of a whole frame.
    always_ff @(posedge clk) begin
        if (we_i) mem_q <= wdata_i;
    end

    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fft_out_serializer.sv
// Parallel-to-serial output end of the 8-point FFT. Captures a full frame
// into a ping-pong pair of frame buffers and streams it out bin by bin over
// valid/ready. Optional divide-by-N scaling is enabled by FFT_OUT_SCALE_EN.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int SHIFT = LOG2N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] b1,
    input  logic [DW-1:0] b5,
    input  logic [DW-1:0] br2,
    input  logic [DW-1:0] br3,
    input  logic [DW-1:0] br4,
    input  logic [DW-1:0] br6,
    input  logic [DW-1:0] br7,
    input  logic [DW-1:0] br8,
    input  logic [DW-1:0] bi2,
    input  logic [DW-1:0] bi3,
    input  logic [DW-1:0] bi4,
    input  logic [DW-1:0] bi6,
    input  logic [DW-1:0] bi7,
    input  logic [DW-1:0] bi8,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          ovf
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic signed [DW:0] SAT_MAX = (DW+1)'((2**(DW-1)) - 1);
    localparam logic signed [DW:0] SAT_MIN = -SAT_MAX - (DW+1)'(1);

    // Round-half-up arithmetic shift, one guard bit of headroom, then saturate.
    function automatic logic [DW-1:0] scale_bin(input logic [DW-1:0] x);
        logic signed [DW:0] ext;
        logic signed [DW:0] rnd;
        logic signed [DW:0] sh;
        ext = {x[DW-1], x};
        rnd = ext + (DW+1)'(2**(SHIFT-1));
        sh  = rnd >>> SHIFT;
        if (sh > SAT_MAX)      scale_bin = SAT_MAX[DW-1:0];
        else if (sh < SAT_MIN) scale_bin = SAT_MIN[DW-1:0];
        else                   scale_bin = sh[DW-1:0];
    endfunction

    logic [0:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_sel_q, rd_sel_q;
    bin_idx_t    rd_idx_q;
    logic        ovf_q;

    logic        cap, drop, pop, last_pop;
    logic [N_PTS-1:0][2*DW-1:0] wframe;
    logic [2*DW-1:0] rdata0, rdata1, rdata;
    logic [DW-1:0]   rd_re, rd_im;

    // Handshake decode; in_ready depends on occupancy only.
    always_comb begin
        in_ready  = (count_q < 2'd2);
        out_valid = (state_q == S_STREAM);
        cap       = in_valid & in_ready;
        drop      = in_valid & ~in_ready;
        pop       = out_valid & out_ready;
        last_pop  = pop & (rd_idx_q == bin_idx_t'(N_PTS-1));
        count_d   = count_q + {1'b0, cap} - {1'b0, last_pop};
        state_d   = (count_d != 2'd0) ? S_STREAM : S_IDLE;
    end

    // Frame assembly: X0 and X4 are purely real.
    always_comb begin
        wframe    = '0;
        wframe[0] = {b1,  {DW{1'b0}}};
        wframe[1] = {br2, bi2};
        wframe[2] = {br3, bi3};
        wframe[3] = {br4, bi4};
        wframe[4] = {b5,  {DW{1'b0}}};
        wframe[5] = {br6, bi6};
        wframe[6] = {br7, bi7};
        wframe[7] = {br8, bi8};
    end

    fft_frame_buf #(.DW(DW)) u_buf_ping (
        .clk      (clk),
        .we_i     (cap & ~wr_sel_q),
        .wdata_i  (wframe),
        .rd_idx_i (rd_idx_q),
        .rdata_o  (rdata0)
    );

    fft_frame_buf #(.DW(DW)) u_buf_pong (
        .clk      (clk),
        .we_i     (cap & wr_sel_q),
        .wdata_i  (wframe),
        .rd_idx_i (rd_idx_q),
        .rdata_o  (rdata1)
    );

    // Occupancy, buffer selects, read pointer, FSM and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= 2'd0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rd_idx_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (cap)      wr_sel_q <= ~wr_sel_q;
            if (last_pop) rd_sel_q <= ~rd_sel_q;
            if (pop)      rd_idx_q <= rd_idx_q + bin_idx_t'(1);
            if (drop)     ovf_q    <= 1'b1;
        end
    end

    // Output datapath; everything reads zero while idle.
    always_comb begin
        rdata = rd_sel_q ? rdata1 : rdata0;
`ifdef FFT_OUT_SCALE_EN
        rd_re = scale_bin(rdata[2*DW-1:DW]);
        rd_im = scale_bin(rdata[DW-1:0]);
`else
        rd_re = rdata[2*DW-1:DW];
        rd_im = rdata[DW-1:0];
`endif
        out_re   = out_valid ? rd_re : '0;
        out_im   = out_valid ? rd_im : '0;
        out_idx  = out_valid ? rd_idx_q : 3'd0;
        out_last = out_valid & (rd_idx_q == bin_idx_t'(N_PTS-1));
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized self-checking bench for fft_out_serializer against a
// frame-queue reference model.
module tb_fft_out_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_last, ovf;
    logic signed [15:0] out_re, out_im;
    logic [2:0] out_idx;
    logic [15:0] fr_re [8];
    logic [15:0] fr_im [8];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: queue of stored frames plus read position in the head.
    logic [7:0][15:0] qre [$];
    logic [7:0][15:0] qim [$];
    int rpos = 0;
    bit movf = 1'b0;

    always #5 clk = ~clk;

    fft_out_serializer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .b1(fr_re[0]), .b5(fr_re[4]),
        .br2(fr_re[1]), .br3(fr_re[2]), .br4(fr_re[3]),
        .br6(fr_re[5]), .br7(fr_re[6]), .br8(fr_re[7]),
        .bi2(fr_im[1]), .bi3(fr_im[2]), .bi4(fr_im[3]),
        .bi6(fr_im[5]), .bi7(fr_im[6]), .bi8(fr_im[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .ovf(ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_scale(input longint x);
`ifdef FFT_OUT_SCALE_EN
        longint v;
        longint q;
        v = x + 4;
        if (v >= 0) q = v / 8;
        else        q = -((-v + 7) / 8);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
`else
        return x;
`endif
    endfunction

    task automatic check_outputs();
        bit v;
        v = (qre.size() > 0);
        chk("in_ready", in_ready, longint'(qre.size() < 2));
        chk("ovf", ovf, movf);
        chk("out_valid", out_valid, v);
        if (v) begin
            chk("out_idx", out_idx, rpos);
            chk("out_last", out_last, longint'(rpos == 7));
            chk("out_re", out_re, ref_scale($signed(qre[0][rpos])));
            chk("out_im", out_im, ref_scale($signed(qim[0][rpos])));
        end else begin
            chk("idle_idx", out_idx, 0);
            chk("idle_last", out_last, 0);
            chk("idle_re", out_re, 0);
            chk("idle_im", out_im, 0);
        end
    endtask

    // Check at the falling edge, advance one clock, update the model.
    task automatic step();
        bit cap, drop, pop;
        logic [7:0][15:0] nre, nim;
        check_outputs();
        cap  = in_valid && (qre.size() < 2);
        drop = in_valid && (qre.size() >= 2);
        pop  = (qre.size() > 0) && out_ready;
        for (int i = 0; i < 8; i++) begin
            nre[i] = fr_re[i];
            nim[i] = (i == 0 || i == 4) ? 16'h0 : fr_im[i];
        end
        @(posedge clk);
        if (drop) movf = 1'b1;
        if (pop) begin
            rpos++;
            if (rpos == 8) begin
                void'(qre.pop_front());
                void'(qim.pop_front());
                rpos = 0;
            end
        end
        if (cap) begin
            qre.push_back(nre);
            qim.push_back(nim);
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 7))
            0:       return 16'h7fff;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = rand_sample();
            fr_im[i] = rand_sample();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
    endtask

    task automatic model_reset();
        qre.delete();
        qim.delete();
        rpos = 0;
        movf = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        check_outputs();           // reset state
        rst = 1'b1;
        @(negedge clk);

        // Single frame Xk = (k+1, -(k+1)); X0/X4 imag forced to zero.
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 16'(i + 1);
            fr_im[i] = 16'(-(i + 1));
        end
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();

        // Two frames while stalled, third dropped, then 16 beats.
        out_ready = 1'b0;
        rand_frame(); in_valid = 1'b1; step();
        rand_frame(); step();
        rand_frame(); step();
        in_valid = 1'b0; step();
        out_ready = 1'b1;
        repeat (18) step();

        // Stall pattern 1,0,0,1 per cycle.
        rand_frame(); in_valid = 1'b1; step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        drain();

        // Capture coinciding with the last beat of the only stored frame.
        rand_frame(); in_valid = 1'b1; out_ready = 1'b1; step();
        in_valid = 1'b0;
        guard = 0;
        while (!(qre.size() == 1 && rpos == 7) && guard < 40) begin
            step();
            guard++;
        end
        chk("wait_idx7", guard < 40, 1);
        rand_frame(); in_valid = 1'b1; step();
        in_valid = 1'b0;
        chk("nobubble_idx", out_idx, 0);
        chk("nobubble_valid", out_valid, 1);
        repeat (9) step();
        drain();

        // Scaling corner values on X0..X2 real parts.
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
        fr_re[0] = 16'd12; fr_re[1] = 16'hfff4; fr_re[2] = 16'h7fff;
        in_valid = 1'b1; out_ready = 1'b0; step();
        in_valid = 1'b0;
`ifdef FFT_OUT_SCALE_EN
        chk("scale_p12", out_re, 2);
        out_ready = 1'b1; step();
        chk("scale_m12", out_re, -1);
        step();
        chk("scale_max", out_re, 4096);
`else
        chk("raw_p12", out_re, 12);
        out_ready = 1'b1; step();
        chk("raw_m12", out_re, -12);
        step();
        chk("raw_max", out_re, 32767);
`endif
        drain();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_frame();
            in_valid  = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset in the middle of a frame.
        rand_frame(); in_valid = 1'b1; out_ready = 1'b1; step();
        rand_frame(); step();
        in_valid = 1'b0;
        guard = 0;
        while (!(qre.size() > 0 && rpos == 3) && guard < 40) begin
            step();
            guard++;
        end
        chk("wait_idx3", guard < 40, 1);
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_last", out_last, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rand_frame(); in_valid = 1'b1; step();
        in_valid = 1'b0;
        chk("post_rst_idx", out_idx, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
